// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg -- shared pipeline constants for the instruction-fetch stage.
//   NOP_INSTR        : encoding inserted into IF/ID on reset and flush
//   RS_/RT_ MSB/LSB  : register-specifier bit positions inside an instruction
//   fetch_state_e    : BOOT/RUN encoding of the fetch-stage FSM
//   pc_plus4()       : sequential PC increment, wraps modulo 2^32
// ---------------------------------------------------------------------------
package if_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int REG_W  = 5;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if -- instruction-memory bus between the fetch stage and imem.
//   imem_addr : current PC (driven by the fetch stage, master)
//   imem_data : instruction word, combinational read of imem_addr (slave)
// ---------------------------------------------------------------------------
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;

  modport master (output imem_addr, input  imem_data);
  modport slave  (input  imem_addr, output imem_data);
endinterface

// File: rtl/if_id_register.sv
// ---------------------------------------------------------------------------
// if_id_register -- IF/ID pipeline register with write-enable, flush and
// valid tracking.
//   clock, reset      : rising-edge clock, synchronous active-low reset
//   write_en          : 0 holds every field (flush ignored while held)
//   flush             : load NOP_WORD with valid cleared
//   boot              : fetch FSM in BOOT; the load is marked not valid
//   instr_in, pc4_in  : fetched word and its PC+4
//   IF_ID_*           : registered instruction, PC+4, valid, Rs and Rt
// ---------------------------------------------------------------------------
module if_id_register
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write_en,
  input  logic             flush,
  input  logic             boot,
  input  logic [31:0]      instr_in,
  input  logic [31:0]      pc4_in,
  output logic [31:0]      IF_ID_instrucao,
  output logic [31:0]      IF_ID_PC4,
  output logic             IF_ID_valido,
  output logic [REG_W-1:0] IF_ID_registradorRs,
  output logic [REG_W-1:0] IF_ID_registradorRt
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q,   pc4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (write_en) begin
      pc4_d = pc4_in;
      if (flush) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end else begin
        instr_d = instr_in;
        // The word fetched during BOOT is not trusted as a real instruction.
        valid_d = ~boot;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      instr_q <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign IF_ID_instrucao     = instr_q;
  assign IF_ID_PC4           = pc4_q;
  assign IF_ID_valido        = valid_q;
  assign IF_ID_registradorRs = instr_q[RS_MSB:RS_LSB];
  assign IF_ID_registradorRt = instr_q[RT_MSB:RT_LSB];

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage: PC register, BOOT/RUN FSM and the
// IF/ID pipeline register (if_id_register).
//   clock, reset     : rising-edge clock, synchronous active-low reset
//   PCWrite          : 0 holds the PC (branch redirect ignored while held)
//   IF_ID_Write      : 0 holds IF/ID (flush ignored while held)
//   PCSrc            : redirect PC to branch_target
//   IF_Flush         : replace the instruction entering IF/ID with NOP_WORD
//   branch_target    : redirect address
//   imem             : instruction-memory bus (imem_addr = PC, imem_data)
//   IF_ID_*          : registered PC+4, instruction, valid, Rs, Rt
// Optional build macro IF_STAGE_STALL_CNT_EN adds stall_count/flush_count.
// ---------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             IF_ID_Write,
  input  logic             PCSrc,
  input  logic             IF_Flush,
  input  logic [31:0]      branch_target,
  if_stage_if.master       imem,
  output logic [31:0]      IF_ID_PC4,
  output logic [31:0]      IF_ID_instrucao,
  output logic             IF_ID_valido,
  output logic [REG_W-1:0] IF_ID_registradorRs,
  output logic [REG_W-1:0] IF_ID_registradorRt
`ifdef IF_STAGE_STALL_CNT_EN
  ,
  output logic [31:0]      stall_count,
  output logic [31:0]      flush_count
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc4;
  logic         boot;

  assign pc4 = pc_plus4(pc_q);

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // FSM next state: BOOT lasts exactly one released edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // FSM outputs
  always_comb begin
    boot = 1'b0;
    if (state_q == ST_BOOT) boot = 1'b1;
  end

  // PC: a stalled branch decision is not final, so hold wins over redirect.
  always_comb begin
    pc_d = pc_q;
    if (PCWrite) begin
      if (PCSrc) pc_d = branch_target;
      else       pc_d = pc4;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign imem.imem_addr = pc_q;

  if_id_register #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clock               (clock),
    .reset               (reset),
    .write_en            (IF_ID_Write),
    .flush               (IF_Flush),
    .boot                (boot),
    .instr_in            (imem.imem_data),
    .pc4_in              (pc4),
    .IF_ID_instrucao     (IF_ID_instrucao),
    .IF_ID_PC4           (IF_ID_PC4),
    .IF_ID_valido        (IF_ID_valido),
    .IF_ID_registradorRs (IF_ID_registradorRs),
    .IF_ID_registradorRt (IF_ID_registradorRt)
  );

`ifdef IF_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Only RUN-state events count; a flush counts only when IF/ID actually loads.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q == ST_RUN) begin
      if (!PCWrite)               stall_cnt_d = stall_cnt_q + 32'd1;
      if (IF_ID_Write && IF_Flush) flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000000, instruction word inserted into IF/ID on flush and reset.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port PCWrite  input  1  from hazard_detection_unit; 0 = hold PC.
REQ-006 SHALL have port IF_ID_Write  input  1  from hazard_detection_unit; 0 = hold IF/ID register.
REQ-007 SHALL have port PCSrc  input  1  branch/jump taken, resolved in ID.
REQ-008 SHALL have port IF_Flush  input  1  discard the instruction currently being fetched.
REQ-009 SHALL have port branch_target  input  32  redirect address when PCSrc=1.
REQ-010 SHALL have port imem_addr  output  32  current PC driven to instruction memory.
REQ-011 SHALL have port imem_data  input  32  instruction word, combinational read of imem_addr.
REQ-012 SHALL have port IF_ID_PC4  output  32  registered PC+4 of the instruction in ID.
REQ-013 SHALL have port IF_ID_instrucao  output  32  registered instruction in ID.
REQ-014 SHALL have port IF_ID_valido  output  1  1 = IF_ID_instrucao is a real fetched instruction.
REQ-015 SHALL have ports IF_ID_registradorRs and IF_ID_registradorRt  output  5  bits [25:21] and [20:16] of IF_ID_instrucao, feeding hazard_detection_unit.

Function
REQ-016 SHALL drive imem_addr directly from the PC register, with no added latency.
REQ-017 SHALL update the PC on each edge, priority order: PCWrite=0 -> hold; else PCSrc=1 -> branch_target; else PC+4.
REQ-018 SHALL ignore PCSrc while PCWrite=0, because a stalled ID-stage branch decision is not final.
REQ-019 SHALL compute PC+4 modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.
REQ-020 SHALL update IF/ID on each edge, priority order: IF_ID_Write=0 -> hold all IF/ID fields, including IF_ID_valido; else IF_Flush=1 -> load NOP_WORD, PC+4, valido=0; else load imem_data, PC+4, valido=1.
REQ-021 SHALL ignore IF_Flush while IF_ID_Write=0.
REQ-022 SHALL give a one-cycle fetch-to-ID latency: an instruction fetched at edge N is visible on IF_ID_* after edge N+1.
REQ-023 SHALL implement a two-state FSM, BOOT and RUN.
REQ-024 SHALL enter BOOT on reset and move to RUN on the first edge with reset=1.
REQ-025 SHALL force IF_ID_valido=0 for the IF/ID load performed in BOOT, regardless of imem_data.
REQ-026 SHALL treat PCWrite=0 with IF_ID_Write=1 as legal; that combination duplicates the fetched instruction into IF/ID.

Reset
REQ-027 SHALL, with reset=0 at an edge, set PC=RESET_PC, IF_ID_instrucao=NOP_WORD, IF_ID_PC4=0, IF_ID_valido=0 and FSM=BOOT.
REQ-028 SHALL give reset priority over PCWrite, IF_ID_Write, PCSrc and IF_Flush.
REQ-029 SHALL, when reset is asserted mid-stall or mid-flush, discard the held state completely.
REQ-030 SHALL leave outputs undefined before the first reset edge; the bench never checks them there.

Configuration
REQ-031 SHALL, when IF_STAGE_STALL_CNT_EN is defined, add outputs stall_count (32) and flush_count (32).
REQ-032 SHALL increment stall_count on each RUN-state edge with PCWrite=0, and flush_count on each RUN-state edge with IF_ID_Write=1 and IF_Flush=1.
REQ-033 SHALL clear both counters on reset and let them wrap modulo 2^32.
REQ-034 SHALL, when IF_STAGE_STALL_CNT_EN is undefined, omit both ports and the counter logic entirely.

Structure
REQ-035 SHALL take the shared pipeline package's constants: NOP encoding, Rs/Rt bit positions, and the BOOT/RUN state encoding.
REQ-036 SHALL use one sub-module, if_id_register, holding the IF/ID fields with its write-enable, flush and valid logic; PC and FSM stay in if_stage.

Verification
REQ-037 SHALL cover sequential fetch: reset with RESET_PC=0, then release, with PCWrite=IF_ID_Write=1 -> imem_addr 0,4,8,12; IF_ID_valido=0 in the first RUN cycle, then 1, with IF_ID_PC4 4,8,12.
REQ-038 SHALL cover a load-use stall: PCWrite=IF_ID_Write=0 for 1 cycle at PC=8 -> imem_addr stays 8, IF_ID_* unchanged, and fetch resumes to 12 next cycle.
REQ-039 SHALL cover a branch: PCSrc=1, IF_Flush=1, branch_target=32'h40 at PC=16 -> next imem_addr=32'h40, IF_ID_instrucao=NOP_WORD, IF_ID_valido=0.
REQ-040 SHALL cover simultaneous events: PCWrite=0, IF_ID_Write=0, PCSrc=1, IF_Flush=1 -> PC and IF/ID held, and the branch is ignored.
REQ-041 SHALL cover wrap-around: PC forced to 32'hFFFFFFFC via branch -> next imem_addr=0, with IF_ID_PC4=0.
REQ-042 SHALL cover reset mid-stall: reset=0 during a stall -> PC=RESET_PC, IF_ID_valido=0, and stall_count=0 when IF_STAGE_STALL_CNT_EN is defined.
